// File: rtl/riscv_pkg.sv
// Shared core types for the instruction-fetch front end.
// XLEN, NOP encoding, fetch FSM states and the IF/ID bundle.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } if_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } if_id_t;

endpackage

// File: rtl/if_prefetch_buf_if.sv
// Instruction-memory request/response bundle.
// master = fetch unit side, slave = memory side.
interface if_prefetch_buf_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_fifo.sv
// Generic synchronous FIFO with push/pop/clear and occupancy count.
// Clear wins over push and pop; push+pop on a full FIFO is accepted.
module if_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage, pointers and occupancy; clear empties without touching data.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rstb)
        !(i_push && !i_clear && w_full && !w_do_pop)
    );

endmodule

// File: rtl/if_prefetch_buf.sv
// Fetch front end: owns the fetch PC, issues imem requests, buffers words.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
module if_prefetch_buf
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rstb,
    if_prefetch_buf_if.master   imem,
    input  logic                Redirect_Valid,
    input  logic [XLEN-1:0]     Redirect_Pc,
    input  logic                Id_PcWrite,
    output logic                IfId_Valid,
    output logic [XLEN-1:0]     IfId_Inst,
    output logic [XLEN-1:0]     IfId_Pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

    if_state_t       r_state;
    if_state_t       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_drop_nxt;
    logic            r_run;

    logic            w_req_valid;
    logic            w_accept;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redir_pc;
    logic [CW-1:0]   w_cnt;
    logic            w_empty;
    logic [2*XLEN-1:0] w_rdata;
    if_id_t          w_head;

    assign w_redir_pc = {Redirect_Pc[XLEN-1:2], 2'b00};
    assign w_rsp      = imem.imem_rsp_valid;

    // r_run keeps the request line low while in reset and for the release cycle.
    assign w_req_valid = r_run && (r_state == RUN) &&
                         (({1'b0, w_cnt} + {1'b0, r_out}) < {1'b0, LP_DEPTH});
    assign w_accept    = w_req_valid && imem.imem_req_ready;

    // A response alongside a redirect belongs to the old path.
    assign w_push = w_rsp && (r_state == RUN) && !Redirect_Valid;
    assign w_pop  = IfId_Valid && Id_PcWrite && !Redirect_Valid;

    assign w_out_nxt = r_out + CW'(w_accept) - CW'(w_rsp);

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_pc;

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (Redirect_Valid),
        .i_wdata ({r_rsp_pc, imem.imem_rsp_data}),
        .o_rdata (w_rdata),
        .o_count (w_cnt),
        .o_empty (w_empty)
    );

    assign w_head     = if_id_t'(w_rdata);
    assign IfId_Valid = !w_empty;
    assign IfId_Inst  = IfId_Valid ? w_head.inst : NOP_INST;
    assign IfId_Pc    = IfId_Valid ? w_head.pc : '0;

    // Next state: redirect with work in flight enters DRAIN; last drop leaves it.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        unique case (r_state)
            RUN: begin
                if (Redirect_Valid && (w_out_nxt != '0)) begin
                    w_state_nxt = DRAIN;
                    w_drop_nxt  = w_out_nxt;
                end
            end
            DRAIN: begin
                if (w_rsp) begin
                    w_drop_nxt = r_drop - CW'(1);
                    if (r_drop == CW'(1)) begin
                        w_state_nxt = RUN;
                    end
                end
            end
        endcase
    end

    // FSM state, drop counter, outstanding counter and release flag.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= RUN;
            r_drop  <= '0;
            r_out   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            r_out   <= w_out_nxt;
            r_run   <= 1'b1;
        end
    end

    // Fetch PC: redirect retargets (even an un-accepted request), accept advances.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_pc <= RESET_PC;
        end else if (Redirect_Valid) begin
            r_pc <= w_redir_pc;
        end else if (w_accept) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    // PC tagged onto the next kept response; in RUN the in-flight
    // requests are always sequential, so this just walks by 4.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rsp_pc <= RESET_PC;
        end else if (Redirect_Valid) begin
            r_rsp_pc <= w_redir_pc;
        end else if (w_push) begin
            r_rsp_pc <= r_rsp_pc + XLEN'(4);
        end
    end

`ifdef IF_PERF_CNT_EN
    logic        w_discard;
    logic [31:0] w_flush_inc;

    assign w_discard   = w_rsp && (Redirect_Valid || (r_state == DRAIN));
    assign w_flush_inc = (Redirect_Valid ? 32'(w_cnt) : 32'd0) +
                         (w_discard ? 32'd1 : 32'd0);

    // Pops delivered to decode and words thrown away by redirects.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(w_pop);
            perf_flush_cnt <= perf_flush_cnt + w_flush_inc;
        end
    end
`endif

    a_out_bound: assert property (
        @(posedge clk) disable iff (!rstb)
        (r_out <= LP_DEPTH) && (r_drop <= LP_DEPTH)
    );

    a_drop_tracks_out: assert property (
        @(posedge clk) disable iff (!rstb)
        (r_state == DRAIN) |-> (r_drop == r_out) && (r_drop != '0)
    );

    a_rsp_expected: assert property (
        @(posedge clk) disable iff (!rstb)
        imem.imem_rsp_valid |-> (r_out != '0)
    );

endmodule
